// File: rtl/stack_op_sequencer.sv
// Stack opcode sequencer: single-cycle ops steer the stack combinationally in the accept cycle (1 op/clk); SWAP takes 4 clks with op_ready low for 3.
// Rejected ops are consumed and flagged one clock later. Optional SWAP support is enabled by defining STACK_OP_SEQ_SWAP_EN.
module stack_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op_code,
  input  logic [WIDTH-1:0]       op_imm,
  input  logic [1:0][WIDTH-1:0]  stack_tops,
  output logic                   stack_push,
  output logic                   stack_pop,
  output logic [WIDTH-1:0]       stack_insert,
  output logic [CW-1:0]          depth,
  output logic                   empty,
  output logic                   full,
  output logic                   err_valid,
  output logic [1:0]             err_code
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_DROP = 3'b010;
  localparam logic [2:0] OP_DUP  = 3'b011;
  localparam logic [2:0] OP_OVER = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;

  localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

  logic [CW-1:0]    r_depth;
  logic             r_err_valid;
  logic [1:0]       r_err_code;

  logic             w_accept;
  logic             w_take;
  logic             w_illegal;
  logic             w_under;
  logic             w_over;
  logic [1:0]       w_err_code;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_insert;

`ifdef STACK_OP_SEQ_SWAP_EN
  typedef enum logic [1:0] {S_IDLE, S_SW_POP2, S_SW_PUSH0, S_SW_PUSH1} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;

  assign op_ready = (r_state == S_IDLE);
`else
  assign op_ready = 1'b1;
`endif

  assign w_accept = op_valid & op_ready & reset_n;
  assign w_take   = w_accept && (w_err_code == 2'b00);

  always_comb begin
    w_illegal = (op_code[2:1] == 2'b11);
`ifndef STACK_OP_SEQ_SWAP_EN
    if (op_code == OP_SWAP) w_illegal = 1'b1;
`endif
    w_under = 1'b0;
    w_over  = 1'b0;
    case (op_code)
      OP_NOP:  ;
      OP_PUSH: w_over = (r_depth == DEPTH_MAX);
      OP_DROP: w_under = (r_depth == '0);
      OP_DUP: begin
        w_under = (r_depth == '0);
        w_over  = (r_depth == DEPTH_MAX);
      end
      OP_OVER: begin
        w_under = (r_depth < CW'(2));
        w_over  = (r_depth == DEPTH_MAX);
      end
      OP_SWAP: w_under = (r_depth < CW'(2));
      default: ;
    endcase
    // Priority: illegal beats underflow beats overflow
    if (w_illegal)    w_err_code = 2'b11;
    else if (w_under) w_err_code = 2'b10;
    else if (w_over)  w_err_code = 2'b01;
    else              w_err_code = 2'b00;
  end

  always_comb begin
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_insert = '0;
    if (w_take) begin
      case (op_code)
        OP_PUSH: begin w_push = 1'b1; w_insert = op_imm;        end
        OP_DROP: w_pop = 1'b1;
        OP_DUP:  begin w_push = 1'b1; w_insert = stack_tops[0]; end
        OP_OVER: begin w_push = 1'b1; w_insert = stack_tops[1]; end
        OP_SWAP: w_pop = 1'b1;
        default: ;
      endcase
    end
`ifdef STACK_OP_SEQ_SWAP_EN
    // Reset abandons a SWAP in flight without issuing its remaining strobes
    if (reset_n) begin
      case (r_state)
        S_SW_POP2:  w_pop = 1'b1;
        S_SW_PUSH0: begin w_push = 1'b1; w_insert = r_t0; end
        S_SW_PUSH1: begin w_push = 1'b1; w_insert = r_t1; end
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_depth     <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= 2'b00;
`ifdef STACK_OP_SEQ_SWAP_EN
      r_state     <= S_IDLE;
`endif
    end else begin
      r_depth     <= r_depth + CW'(w_push) - CW'(w_pop);
      r_err_valid <= w_accept && (w_err_code != 2'b00);
      if (w_accept && (w_err_code != 2'b00)) r_err_code <= w_err_code;
`ifdef STACK_OP_SEQ_SWAP_EN
      case (r_state)
        S_IDLE: begin
          if (w_take && (op_code == OP_SWAP)) begin
            r_state <= S_SW_POP2;
            r_t0    <= stack_tops[0];
            r_t1    <= stack_tops[1];
          end
        end
        S_SW_POP2:  r_state <= S_SW_PUSH0;
        S_SW_PUSH0: r_state <= S_SW_PUSH1;
        default:    r_state <= S_IDLE;
      endcase
`endif
    end
  end

  assign stack_push   = w_push;
  assign stack_pop    = w_pop;
  assign stack_insert = w_insert;
  assign depth        = r_depth;
  assign empty        = (r_depth == '0);
  assign full         = (r_depth == DEPTH_MAX);
  assign err_valid    = r_err_valid;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: an array-backed stack answers the DUT's strobes, and a queue-based reference predicts every op.
module tb_stack_op_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef STACK_OP_SEQ_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  op_valid = 1'b0;
  logic                  op_ready;
  logic [2:0]            op_code = 3'b000;
  logic [WIDTH-1:0]      op_imm = '0;
  logic [1:0][WIDTH-1:0] stack_tops;
  logic                  stack_push, stack_pop;
  logic [WIDTH-1:0]      stack_insert;
  logic [CW-1:0]         depth;
  logic                  empty, full, err_valid;
  logic [1:0]            err_code;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .stack_tops(stack_tops),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_insert(stack_insert),
    .depth(depth), .empty(empty), .full(full), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // The register stack being driven
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp = 0;
  always @(posedge clk) begin
    if (!reset_n) sp <= 0;
    else if (stack_push && sp < DEPTH) begin mem[sp] <= stack_insert; sp <= sp + 1; end
    else if (stack_pop && sp > 0) sp <= sp - 1;
  end
  always_comb begin
    stack_tops[0] = (sp >= 1) ? mem[sp-1] : '0;
    stack_tops[1] = (sp >= 2) ? mem[sp-2] : '0;
  end

  logic [WIDTH-1:0] q[$];  // reference stack, q[0] is the top
  int               n_checks = 0;
  int               n_errors = 0;
  bit               exp_ev = 1'b0;
  logic [1:0]       exp_ec = 2'b00;
  int               exp_d = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_status(input bit chk_tops);
    check("err_valid", err_valid, exp_ev);
    check("err_code", err_code, exp_ec);
    check("depth", depth, exp_d);
    check("empty", empty, exp_d == 0);
    check("full", full, exp_d == DEPTH);
    check("push_pop_mutex", stack_push & stack_pop, 1'b0);
    if (chk_tops && q.size() >= 1) check("top0", stack_tops[0], q[0]);
    if (chk_tops && q.size() >= 2) check("top1", stack_tops[1], q[1]);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk_status(1'b1);
      check("idle_ready", op_ready, 1'b1);
      check("idle_push", stack_push, 1'b0);
      check("idle_pop", stack_pop, 1'b0);
      @(posedge clk); #1;
      exp_ev = 1'b0;
    end
  endtask

  task automatic do_op(input logic [2:0] c, input logic [WIDTH-1:0] imm);
    int               d, n;
    logic [1:0]       e;
    bit               ep[4];
    bit               epop[4];
    logic [WIDTH-1:0] ins[4];
    logic [WIDTH-1:0] t;
    d = q.size();
    n = 1;
    for (int k = 0; k < 4; k++) begin ep[k] = 1'b0; epop[k] = 1'b0; ins[k] = '0; end
    if (c[2:1] == 2'b11 || (c == 3'd5 && !SWAP_EN))                   e = 2'b11;
    else if ((c == 3'd2 || c == 3'd3) && d < 1)                      e = 2'b10;
    else if ((c == 3'd4 || c == 3'd5) && d < 2)                      e = 2'b10;
    else if ((c == 3'd1 || c == 3'd3 || c == 3'd4) && d == DEPTH)    e = 2'b01;
    else                                                             e = 2'b00;
    if (e == 2'b00) begin
      case (c)
        3'd1: begin ep[0] = 1'b1; ins[0] = imm;  end
        3'd2: epop[0] = 1'b1;
        3'd3: begin ep[0] = 1'b1; ins[0] = q[0]; end
        3'd4: begin ep[0] = 1'b1; ins[0] = q[1]; end
        3'd5: begin
          n = 4;
          epop[0] = 1'b1; epop[1] = 1'b1;
          ep[2] = 1'b1; ins[2] = q[0];
          ep[3] = 1'b1; ins[3] = q[1];
        end
        default: ;
      endcase
    end
    op_valid = 1'b1; op_code = c; op_imm = imm;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_status(k == 0);
      check("op_ready", op_ready, k == 0);
      check("push", stack_push, ep[k]);
      check("pop", stack_pop, epop[k]);
      if (ep[k]) check("insert", stack_insert, ins[k]);
      @(posedge clk); #1;
      exp_d = exp_d + int'(ep[k]) - int'(epop[k]);
      exp_ev = (k == 0) && (e != 2'b00);
      if (k == 0 && e != 2'b00) exp_ec = e;
      // Keep offering an illegal op while busy; it must be ignored
      op_valid = (k < n - 1);
      op_code = 3'b110;
    end
    if (e == 2'b00) begin
      case (c)
        3'd1: q.push_front(imm);
        3'd2: void'(q.pop_front());
        3'd3: begin t = q[0]; q.push_front(t); end
        3'd4: begin t = q[1]; q.push_front(t); end
        3'd5: begin t = q[0]; q[0] = q[1]; q[1] = t; end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q.delete(); exp_d = 0; exp_ev = 1'b0; exp_ec = 2'b00;
    @(negedge clk);
    chk_status(1'b0);
    check("rst_ready", op_ready, 1'b1);
    check("rst_push", stack_push, 1'b0);
    check("rst_pop", stack_pop, 1'b0);
    check("rst_insert", stack_insert, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    do_op(3'd1, 32'hA); do_op(3'd1, 32'hB); do_op(3'd1, 32'hC);
    idle(1);
    do_op(3'd5, 32'h0);  // SWAP of C,B (illegal without SWAP support)
    idle(1);
    do_op(3'd5, 32'h0);
    idle(1);
    do_op(3'd3, 32'h0); do_op(3'd4, 32'h0);
    idle(1);
    while (q.size() < DEPTH) do_op(3'd1, $urandom);
    do_op(3'd1, 32'h1);
    idle(1);
    do_op(3'd3, 32'h0);
    do_op(3'd0, 32'h0);
    idle(1);

    do_reset();
    do_op(3'd2, 32'h0);
    do_op(3'd6, 32'h0);
    do_op(3'd7, 32'h0);
    do_op(3'd0, 32'h0);
    do_op(3'd1, 32'h55);
    do_op(3'd4, 32'h0);
    do_op(3'd5, 32'h0);
    idle(2);

`ifdef STACK_OP_SEQ_SWAP_EN
    do_op(3'd1, 32'h77);
    idle(1);
    op_valid = 1'b1; op_code = 3'd5; op_imm = '0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;  // now in SW_PUSH0
    @(negedge clk);
    check("midswap_rst_push", stack_push, 1'b0);
    check("midswap_rst_pop", stack_pop, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete(); exp_d = 0; exp_ev = 1'b0; exp_ec = 2'b00;
    @(negedge clk);
    check("midswap_ready", op_ready, 1'b1);
    check("midswap_depth", depth, 0);
    check("midswap_push", stack_push, 1'b0);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 400; i++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) c = 3'd1;
      do_op(c, $urandom);
      if ($urandom_range(0, 9) == 0) idle(1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
